flow_stat_acc: RTL and testbench
================================

// Module: flow_stat_acc
// PURPOSE
//  Per-flow statistics accumulator. Counts bytes and packets for up to 2**A_WIDTH flows.
//  Host reads any flow through a strobe/valid port; the read optionally clears the flow.
//  Counters can saturate instead of wrapping. Every entry is cleared by hardware after reset.
//  Sits between the packet classifier (flow number + size per packet) and the host stats block.
// PARAMETERS
//  A_WIDTH    10  flow-number width; table depth = 2**A_WIDTH
//  BYTE_W     32  byte-counter width
//  PKT_W      16  packet-counter width
//  SIZE_W     16  packet-size width (SIZE_W <= BYTE_W)
//  SATURATE   1   1: counters stick at all-ones; 0: counters wrap modulo 2**W
//  CLR_ON_RD  1   1: a read zeroes the flow entry; 0: the read leaves it intact
// PORTS
//  clk_i          in   1        clock
//  rst_i          in   1        reset, asynchronous, active-low
//  rx_flow_num_i  in   A_WIDTH  flow number of the packet being counted
//  pkt_size_i     in   SIZE_W   packet size in bytes
//  pkt_size_en_i  in   1        count one packet this cycle
//  rd_stb_i       in   1        read request this cycle
//  rd_flow_num_i  in   A_WIDTH  flow number to read
//  rd_bytes_o     out  BYTE_W   byte count of the read flow
//  rd_pkts_o      out  PKT_W    packet count of the read flow
//  rd_sat_o       out  1        sticky flag: a counter of this flow saturated/wrapped since its last clear
//  rd_data_val_o  out  1        read data valid, one-cycle pulse
//  ready_o        out  1        table initialised; inputs are accepted
// BEHAVIOUR
//  Reset (asynchronous, active-low):
//   - rd_* outputs, rd_data_val_o and ready_o go to 0. Pipeline valids go to 0. FSM goes to INIT.
//   - The table itself is not reset.
//  FSM states:
//   - INIT: writes {0,0,0} to address 0..2**A_WIDTH-1, one entry per cycle. ready_o=0.
//     pkt_size_en_i and rd_stb_i are ignored and dropped.
//   - After the last address, INIT->RUN. ready_o=1 from the next cycle. RUN is held until reset.
//  Pipeline, RUN only:
//   - S1 registers both requests.
//   - S2 reads the table (combinational read of registered addresses), computes, and writes at the end of S2.
//   - Rd latency = 2: rd_stb_i sampled at edge N -> rd_data_val_o=1 and data valid in the cycle after edge N+1.
//   - rd_data_val_o=0 and rd_* outputs = 0 in every cycle without valid data.
//  Update: bytes += pkt_size_i; pkts += 1.
//   - pkt_size_i=0 still increments pkts.
//   - Sum width is BYTE_W+1 / PKT_W+1. A carry out sets the entry's sat bit.
//   - The written value is all-ones if SATURATE=1, otherwise the truncated sum.
//  Ordering:
//   - An update accepted at edge N is seen by every read sampled at edge >= N.
//  Update and read to the SAME flow in the same cycle:
//   - The read returns old+update (sat included).
//   - CLR_ON_RD=1: the entry is written 0. The packet is counted exactly once, in the read.
//   - CLR_ON_RD=0: the entry is written old+update.
//  Update and read to DIFFERENT flows in the same cycle:
//   - Both complete in the same cycle. The table has 2 read ports and 2 write ports; neither request stalls.
//  Back-to-back:
//   - Updates or reads on consecutive cycles to the same flow need no bubbles. Each S2 sees the prior S2 write.
//  Reset mid-operation:
//   - In-flight requests are lost. Outputs go to 0 asynchronously. INIT re-clears the whole table.
// STRUCTURE
//  Package flow_stat_pkg:
//   - typedef flow_entry_t {logic sat; logic [PKT_W-1:0] pkts; logic [BYTE_W-1:0] bytes}
//   - typedef fsm_e {INIT, RUN}
//   - function sat_add(), which returns the sum plus a carry flag
//  One sub-module, flow_stat_ram:
//   - 2R/2W register array of flow_entry_t
//   - write-port B (clear/init) has priority over write-port A (update) on an address collision
//  Top: INIT FSM/address counter, S1/S2 registers, collision merge, output registers.
// TESTING
//  1. Reset release:
//     - ready_o=0 for exactly 1024 cycles, then 1.
//     - Then rd flow 0, flow 1023 -> bytes=0, pkts=0, sat=0.
//  2. Three updates to flow 4 (sizes 100, 200, 300), then rd flow 4 -> bytes=600, pkts=3.
//     - Immediate re-read -> 0/0 (CLR_ON_RD=1).
//  3. Same-cycle update flow 3 (size 50) and rd flow 3, with prior bytes=10 -> read returns 60/pkts+1.
//     - Next read -> 0.
//     - Same cycle, different flows (update 5, rd 7): both correct, no drop.
//  4. BYTE_W=8, SATURATE=1: sizes 200 then 100 on flow 2 -> bytes=255, sat=1.
//     - With SATURATE=0 -> bytes=44, sat=1.
//  5. Requests during INIT are dropped:
//     - update flow 9 (size 77) while ready_o=0; after ready, rd flow 9 -> 0. rd_stb_i during INIT gives no valid.
//  6. Reset asserted mid-stream:
//     - all outputs 0 immediately; ready_o=0; after re-INIT, every sampled flow reads 0.

Source files
------------

// File: rtl/flow_stat_pkg.sv
// Shared types and the carry-aware adder used by the flow statistics accumulator.
package flow_stat_pkg;

   localparam int unsigned DEF_BYTE_W = 32;
   localparam int unsigned DEF_PKT_W  = 16;

   typedef struct packed {
      logic                  sat;
      logic [DEF_PKT_W-1:0]  pkts;
      logic [DEF_BYTE_W-1:0] bytes;
   } flow_entry_t;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} fsm_e;

   typedef struct packed {
      logic        carry;
      logic [63:0] sum;
   } add_res_t;

   // Adds two w-bit operands; carry is bit w of the full sum. On carry the
   // result is all-ones when sat_en is set, otherwise the truncated sum.
   function automatic add_res_t sat_add(input logic [63:0] a, input logic [63:0] b,
                                        input logic [6:0] w, input logic sat_en);
      logic [64:0] full;
      logic [63:0] mask;
      add_res_t    r;
      full    = {1'b0, a} + {1'b0, b};
      mask    = (64'd1 << w) - 64'd1;
      r.carry = full[w];
      r.sum   = (r.carry && sat_en) ? mask : (full[63:0] & mask);
      return r;
   endfunction

endpackage

// File: rtl/flow_stat_ram.sv
// Register array with two combinational read ports and two write ports;
// write port B wins over write port A when both hit the same address.
module flow_stat_ram
   import flow_stat_pkg::*;
#(
   parameter int unsigned A_WIDTH = 10,
   parameter int unsigned EW      = 49
) (
   input  logic               clk_i,
   input  logic [A_WIDTH-1:0] ra_addr_i,
   output logic [EW-1:0]      ra_data_o,
   input  logic [A_WIDTH-1:0] rb_addr_i,
   output logic [EW-1:0]      rb_data_o,
   input  logic               wa_en_i,
   input  logic [A_WIDTH-1:0] wa_addr_i,
   input  logic [EW-1:0]      wa_data_i,
   input  logic               wb_en_i,
   input  logic [A_WIDTH-1:0] wb_addr_i,
   input  logic [EW-1:0]      wb_data_i
);

   logic [EW-1:0] mem_q [2**A_WIDTH];

   assign ra_data_o = mem_q[ra_addr_i];
   assign rb_data_o = mem_q[rb_addr_i];

   // The later assignment takes effect, giving port B priority.
   always_ff @(posedge clk_i) begin
      if (wa_en_i) mem_q[wa_addr_i] <= wa_data_i;
      if (wb_en_i) mem_q[wb_addr_i] <= wb_data_i;
   end

endmodule

// File: rtl/flow_stat_acc.sv
// Per-flow byte/packet accumulator: clears the table after reset, then runs a
// two-stage update/read pipeline with same-flow merge and optional clear-on-read.
module flow_stat_acc
   import flow_stat_pkg::*;
#(
   parameter int unsigned A_WIDTH   = 10,
   parameter int unsigned BYTE_W    = 32,
   parameter int unsigned PKT_W     = 16,
   parameter int unsigned SIZE_W    = 16,
   parameter bit          SATURATE  = 1'b1,
   parameter bit          CLR_ON_RD = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [A_WIDTH-1:0] rx_flow_num_i,
   input  logic [SIZE_W-1:0]  pkt_size_i,
   input  logic               pkt_size_en_i,
   input  logic               rd_stb_i,
   input  logic [A_WIDTH-1:0] rd_flow_num_i,
   output logic [BYTE_W-1:0]  rd_bytes_o,
   output logic [PKT_W-1:0]   rd_pkts_o,
   output logic               rd_sat_o,
   output logic               rd_data_val_o,
   output logic               ready_o
);

   localparam int unsigned EW = 1 + PKT_W + BYTE_W;
   localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

   typedef struct packed {
      logic              sat;
      logic [PKT_W-1:0]  pkts;
      logic [BYTE_W-1:0] bytes;
   } entry_t;

   fsm_e               state_q, state_d;
   logic [A_WIDTH-1:0] init_addr_q, init_addr_d;
   logic               run, init_we;

   logic               s1_upd_vld_q, s1_upd_vld_d, s1_rd_vld_q, s1_rd_vld_d;
   logic [A_WIDTH-1:0] s1_upd_flow_q, s1_upd_flow_d, s1_rd_flow_q, s1_rd_flow_d;
   logic [SIZE_W-1:0]  s1_size_q, s1_size_d;

   entry_t             old_u, old_r, new_u, rd_val, rd_q, rd_d;
   logic               rd_vld_q, rd_vld_d;
   logic [EW-1:0]      ra_data, rb_data;
   add_res_t           add_b, add_p;
   logic               same_flow, wb_en;
   logic [A_WIDTH-1:0] wb_addr;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= INIT;
         init_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      if (state_q == INIT) begin
         init_addr_d = init_addr_q + 1'b1;
         if (init_addr_q == LAST_ADDR) state_d = RUN;
      end
   end

   always_comb begin
      run     = (state_q == RUN);
      init_we = (state_q == INIT);
   end

   assign ready_o = run;

   // Requests are only captured once the table is fully cleared.
   always_comb begin
      s1_upd_vld_d  = pkt_size_en_i & run;
      s1_upd_flow_d = rx_flow_num_i;
      s1_size_d     = pkt_size_i;
      s1_rd_vld_d   = rd_stb_i & run;
      s1_rd_flow_d  = rd_flow_num_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         s1_upd_vld_q  <= 1'b0;
         s1_upd_flow_q <= '0;
         s1_size_q     <= '0;
         s1_rd_vld_q   <= 1'b0;
         s1_rd_flow_q  <= '0;
         rd_vld_q      <= 1'b0;
         rd_q          <= '0;
      end else begin
         s1_upd_vld_q  <= s1_upd_vld_d;
         s1_upd_flow_q <= s1_upd_flow_d;
         s1_size_q     <= s1_size_d;
         s1_rd_vld_q   <= s1_rd_vld_d;
         s1_rd_flow_q  <= s1_rd_flow_d;
         rd_vld_q      <= rd_vld_d;
         rd_q          <= rd_d;
      end
   end

   assign old_u = entry_t'(ra_data);
   assign old_r = entry_t'(rb_data);

   // Port B clears: the whole table during INIT, or the read flow on clear-on-read.
   // A same-flow read returns the freshly updated entry, and the clear then wins.
   always_comb begin
      add_b       = sat_add(64'(old_u.bytes), 64'(s1_size_q), 7'(BYTE_W), SATURATE);
      add_p       = sat_add(64'(old_u.pkts), 64'd1, 7'(PKT_W), SATURATE);
      new_u.sat   = old_u.sat | add_b.carry | add_p.carry;
      new_u.pkts  = add_p.sum[PKT_W-1:0];
      new_u.bytes = add_b.sum[BYTE_W-1:0];
      same_flow   = s1_upd_vld_q && s1_rd_vld_q && (s1_upd_flow_q == s1_rd_flow_q);
      rd_val      = same_flow ? new_u : old_r;
      wb_en       = init_we | (s1_rd_vld_q & CLR_ON_RD);
      wb_addr     = init_we ? init_addr_q : s1_rd_flow_q;
      rd_vld_d    = s1_rd_vld_q;
      rd_d        = s1_rd_vld_q ? rd_val : '0;
   end

   flow_stat_ram #(.A_WIDTH(A_WIDTH), .EW(EW)) u_ram (
      .clk_i     (clk_i),
      .ra_addr_i (s1_upd_flow_q),
      .ra_data_o (ra_data),
      .rb_addr_i (s1_rd_flow_q),
      .rb_data_o (rb_data),
      .wa_en_i   (s1_upd_vld_q),
      .wa_addr_i (s1_upd_flow_q),
      .wa_data_i (EW'(new_u)),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .wb_data_i ('0)
   );

   assign rd_bytes_o    = rd_q.bytes;
   assign rd_pkts_o     = rd_q.pkts;
   assign rd_sat_o      = rd_q.sat;
   assign rd_data_val_o = rd_vld_q;

endmodule

// File: tb/tb_flow_stat_acc.sv
// Randomised and directed bench for flow_stat_acc against a per-flow array model,
// plus two narrow instances for saturate/wrap behaviour.
module tb_flow_stat_acc;

   localparam int     DEPTH = 1024;
   localparam longint BMAX  = 64'hFFFF_FFFF;
   localparam longint PMAX  = 64'hFFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [9:0]  rx_flow, rd_flow;
   logic [15:0] pkt_size;
   logic        pkt_en, rd_stb;
   logic [31:0] rd_bytes;
   logic [15:0] rd_pkts;
   logic        rd_sat, rd_val, ready;

   logic [1:0]  s_flow, s_rflow;
   logic [7:0]  s_size;
   logic        s_en, s_rd;
   logic [7:0]  a_bytes, b_bytes;
   logic [3:0]  a_pkts, b_pkts;
   logic        a_sat, a_val, a_rdy, b_sat, b_val, b_rdy;

   flow_stat_acc dut (
      .clk_i(clk), .rst_i(rst), .rx_flow_num_i(rx_flow), .pkt_size_i(pkt_size),
      .pkt_size_en_i(pkt_en), .rd_stb_i(rd_stb), .rd_flow_num_i(rd_flow),
      .rd_bytes_o(rd_bytes), .rd_pkts_o(rd_pkts), .rd_sat_o(rd_sat),
      .rd_data_val_o(rd_val), .ready_o(ready));

   flow_stat_acc #(.A_WIDTH(2), .BYTE_W(8), .PKT_W(4), .SIZE_W(8),
                   .SATURATE(1'b1), .CLR_ON_RD(1'b1)) dut_sat (
      .clk_i(clk), .rst_i(rst), .rx_flow_num_i(s_flow), .pkt_size_i(s_size),
      .pkt_size_en_i(s_en), .rd_stb_i(s_rd), .rd_flow_num_i(s_rflow),
      .rd_bytes_o(a_bytes), .rd_pkts_o(a_pkts), .rd_sat_o(a_sat),
      .rd_data_val_o(a_val), .ready_o(a_rdy));

   flow_stat_acc #(.A_WIDTH(2), .BYTE_W(8), .PKT_W(4), .SIZE_W(8),
                   .SATURATE(1'b0), .CLR_ON_RD(1'b1)) dut_wrap (
      .clk_i(clk), .rst_i(rst), .rx_flow_num_i(s_flow), .pkt_size_i(s_size),
      .pkt_size_en_i(s_en), .rd_stb_i(s_rd), .rd_flow_num_i(s_rflow),
      .rd_bytes_o(b_bytes), .rd_pkts_o(b_pkts), .rd_sat_o(b_sat),
      .rd_data_val_o(b_val), .ready_o(b_rdy));

   int total = 0;
   int bad   = 0;

   longint edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   longint      m_bytes [DEPTH];
   longint      m_pkts  [DEPTH];
   bit          m_sat   [DEPTH];
   logic [48:0] exp_q[$];
   longint      due_q[$];
   logic [48:0] cap_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_bytes[i] = 0;
         m_pkts[i]  = 0;
         m_sat[i]   = 1'b0;
      end
   endtask

   // Update first, then read, so a same-cycle read sees the packet it shares.
   task automatic model_apply(input bit ue, input int uf, input int us, input bit re, input int rf);
      if (ue) begin
         m_bytes[uf] += us;
         m_pkts[uf]  += 1;
         if (m_bytes[uf] > BMAX) begin
            m_sat[uf]   = 1'b1;
            m_bytes[uf] = BMAX;
         end
         if (m_pkts[uf] > PMAX) begin
            m_sat[uf]  = 1'b1;
            m_pkts[uf] = PMAX;
         end
      end
      if (re) begin
         exp_q.push_back({m_sat[rf], 16'(m_pkts[rf]), 32'(m_bytes[rf])});
         due_q.push_back(edge_cnt + 2);
         m_bytes[rf] = 0;
         m_pkts[rf]  = 0;
         m_sat[rf]   = 1'b0;
      end
   endtask

   task automatic step(input bit ue, input int uf, input int us, input bit re, input int rf);
      @(negedge clk);
      pkt_en   = ue;
      rx_flow  = 10'(uf);
      pkt_size = 16'(us);
      rd_stb   = re;
      rd_flow  = 10'(rf);
      if (ready) model_apply(ue, uf, us, re, rf);
   endtask

   task automatic drain();
      int n = 0;
      while (due_q.size() > 0 && n < 20) begin
         step(0, 0, 0, 0, 0);
         n++;
      end
      check("drain_timeout", 64'(due_q.size()), 0);
   endtask

   task automatic expect_rd(input string name, input longint b, input longint p, input bit s);
      logic [48:0] c;
      if (cap_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got no read data expected %0d/%0d/%0d", name, b, p, s);
      end else begin
         c = cap_q.pop_front();
         check(name, 64'(c), 64'({s, 16'(p), 32'(b)}));
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("ready_timeout", 64'(ready), 1);
   endtask

   // Every cycle: either a read is due and must match, or outputs must be idle zero.
   initial begin
      logic [48:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (due_q.size() > 0 && due_q[0] == edge_cnt) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            check("rd_valid", 64'(rd_val), 1);
            check("rd_data", 64'({rd_sat, rd_pkts, rd_bytes}), 64'(e));
            cap_q.push_back({rd_sat, rd_pkts, rd_bytes});
         end else begin
            check("idle_valid", 64'(rd_val), 0);
            check("idle_data", 64'({rd_sat, rd_pkts, rd_bytes}), 0);
         end
      end
   end

   initial begin
      int n;
      int uf, rf;
      rst = 1'b0;
      {pkt_en, rd_stb, rx_flow, rd_flow, pkt_size} = '0;
      {s_en, s_rd, s_flow, s_rflow, s_size} = '0;
      model_clear();
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ready), 0);
      check("rst_val", 64'(rd_val), 0);
      rst = 1'b1;

      // Reset release: count cycles with ready low, and inject requests during INIT.
      n = 0;
      while (ready == 1'b0 && n < 3000) begin
         n++;
         pkt_en   = (n == 5);
         rd_stb   = (n == 5) || (n == 6);
         rx_flow  = 10'd9;
         rd_flow  = 10'd9;
         pkt_size = 16'd77;
         @(negedge clk);
      end
      check("init_cycles", 64'(n), 1024);
      check("ready_after_init", 64'(ready), 1);

      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1023);
      step(0, 0, 0, 1, 9);
      drain();
      expect_rd("init_flow0", 0, 0, 0);
      expect_rd("init_flow1023", 0, 0, 0);
      expect_rd("init_dropped_flow9", 0, 0, 0);

      step(1, 4, 100, 0, 0);
      step(1, 4, 200, 0, 0);
      step(1, 4, 300, 0, 0);
      step(0, 0, 0, 1, 4);
      step(0, 0, 0, 1, 4);
      drain();
      expect_rd("flow4_sum", 600, 3, 0);
      expect_rd("flow4_cleared", 0, 0, 0);

      step(1, 3, 10, 0, 0);
      step(1, 3, 50, 1, 3);
      step(0, 0, 0, 1, 3);
      step(1, 7, 11, 0, 0);
      step(1, 5, 30, 1, 7);
      step(0, 0, 0, 1, 5);
      drain();
      expect_rd("same_cycle_merge", 60, 2, 0);
      expect_rd("same_cycle_cleared", 0, 0, 0);
      expect_rd("diff_flow_read7", 11, 1, 0);
      expect_rd("diff_flow_upd5", 30, 1, 0);

      // Narrow instances: 200 + 100 overflows an 8-bit byte counter.
      @(negedge clk);
      s_en = 1'b1; s_flow = 2'd2; s_size = 8'd200;
      @(negedge clk);
      s_size = 8'd100;
      @(negedge clk);
      s_en = 1'b0; s_rd = 1'b1; s_rflow = 2'd2;
      @(negedge clk);
      s_rd = 1'b0;
      @(posedge clk);
      #1;
      check("sat_val", 64'(a_val), 1);
      check("sat_bytes", 64'(a_bytes), 255);
      check("sat_pkts", 64'(a_pkts), 2);
      check("sat_flag", 64'(a_sat), 1);
      check("wrap_val", 64'(b_val), 1);
      check("wrap_bytes", 64'(b_bytes), 44);
      check("wrap_flag", 64'(b_sat), 1);
      @(posedge clk);
      #1;
      check("sat_val_pulse", 64'(a_val), 0);

      for (int i = 0; i < 400; i++) begin
         uf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 7);
         rf = ($urandom_range(0, 3) == 0) ? uf : $urandom_range(0, 7);
         step($urandom_range(0, 1),
              uf,
              ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535),
              $urandom_range(0, 2) == 0,
              rf);
      end
      for (int f = 0; f < 8; f++) step(0, 0, 0, 1, f);
      drain();
      cap_q.delete();

      // Reset with traffic in flight, then confirm re-INIT wiped the table.
      step(1, 1, 500, 0, 0);
      step(1, 1000, 7, 0, 0);
      step(1, 2, 9, 1, 2);
      @(posedge clk);
      #3;
      rst = 1'b0;
      exp_q.delete();
      due_q.delete();
      #1;
      check("midrst_val", 64'(rd_val), 0);
      check("midrst_data", 64'({rd_sat, rd_pkts, rd_bytes}), 0);
      check("midrst_ready", 64'(ready), 0);
      model_clear();
      @(negedge clk);
      {pkt_en, rd_stb} = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wait_ready();
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 2);
      step(0, 0, 0, 1, 1000);
      step(0, 0, 0, 1, 0);
      drain();
      expect_rd("reinit_flow1", 0, 0, 0);
      expect_rd("reinit_flow2", 0, 0, 0);
      expect_rd("reinit_flow1000", 0, 0, 0);
      expect_rd("reinit_flow0", 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
